mem_access_unit: RTL
====================

# mem_access_unit

Data-memory responder for the RV32IM pipelined core: consumes the 4-bit `read_write` access code produced by the decoder and carried through EX/MEM, and turns it into a single-outstanding request/acknowledge bus transaction. It generates byte enables and lane-replicated store data, extracts and sign- or zero-extends load data, and stalls the pipeline until the access completes. It sits in the MEM stage between the pipeline register and the data memory or bus.

## Interface
- `TIMEOUT`, 64: cycles to wait for `bus_ack_i` before aborting with an error (≥2).
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: MEM stage holds a valid instruction.
- `read_write_i` in 4: access code; bit3=0 means no access.
- `addr_i` in 32: byte address from the ALU.
- `store_data_i` in 32: rs2 value.
- `stall_o` out 1: freeze IF..MEM.
- `load_data_o` out 32: extended load result, valid with `load_valid_o`.
- `load_valid_o` out 1: one-cycle completion pulse for a load.
- `err_o` out 1: one-cycle pulse on misalignment trap or timeout.
- `bus_req_o` out 1: request, held until ack.
- `bus_we_o` out 1: 1 = write.
- `bus_addr_o` out 32: word-aligned address, {addr[31:2],2'b00}.
- `bus_be_o` out 4: byte enables.
- `bus_wdata_o` out 32: store data.
- `bus_ack_i` in 1: one-cycle completion from memory.
- `bus_rdata_i` in 32: read word, valid with ack.

## Operation
- Codes: 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU, 1011 SB, 1110 SH, 1111 SW. All eight 1xxx codes are defined. 0xxx means no access, and `stall_o` stays 0.
- FSM states are IDLE, BUS, DONE.
- IDLE:
  - `req_valid_i & read_write_i[3]` accepts the access. Code, address and store data are latched, and the FSM goes to BUS.
  - On a misaligned access with the trap enabled, the FSM goes straight to DONE with the error flagged.
- BUS:
  - `bus_req_o`=1 with stable `bus_addr_o`, `bus_we_o`, `bus_be_o` and `bus_wdata_o`.
  - `bus_ack_i` captures `bus_rdata_i` and moves to DONE.
  - The timeout counter resets on entry and increments each BUS cycle without ack. When it reaches TIMEOUT-1 with no ack, the FSM goes to DONE with the error flagged, and `bus_req_o` drops.
- DONE (one cycle):
  - `load_valid_o`=1 for loads; stores produce no load pulse.
  - `err_o`=1 if the access was flagged.
  - `stall_o`=0. Next state is IDLE.
- Byte enables:
  - Byte: 0001<<a[1:0].
  - Half: 0011<<{a[1],0}.
  - Word: 1111.
  - Loads drive the same enables as stores of the same size.
- Store data:
  - SB: {4{d[7:0]}}.
  - SH: {2{d[15:0]}}.
  - SW: d.
- Load extraction:
  - Byte: lane a[1:0].
  - Half: lane a[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- On an errored load, `load_data_o` = 0.
- `bus_ack_i` outside BUS is ignored.
- `req_valid_i` and code changes while in BUS or DONE are ignored; the latched copies are used.

## Timing
- `stall_o` is combinational:
  - 1 in IDLE when an access is being accepted.
  - 1 throughout BUS.
  - 0 in DONE.
- Accept at cycle 0 puts `bus_req_o` high in cycle 1.
- Ack in cycle k puts DONE, `load_valid_o` and released stall in cycle k+1. With zero-wait memory (ack in cycle 1), the pipeline stalls 2 cycles.
- Timeout: `bus_req_o` is high for exactly TIMEOUT cycles, then `err_o` asserts in the following cycle.
- Back-to-back accesses: the next instruction is accepted in the cycle after DONE, so there is no idle bubble beyond the IDLE accept.
- Reset asserted at any time:
  - FSM goes to IDLE and the counter clears.
  - Every output goes to 0 immediately, including `bus_req_o` mid-transaction.
  - A pending ack is discarded.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Halfword with a[0]=1, or word with a[1:0]≠0, issues no bus cycle.
  - IDLE→DONE with `err_o`=1, and `stall_o` high for the accept cycle only.
- Not defined:
  - Misaligned low bits are masked: half uses {a[1],0}, word uses 00.
  - The access proceeds normally and `err_o` only ever signals timeout.

## Test plan
- LB 1000, addr 0x103, memory word 0x80AA_5511, ack in cycle 1.
  - Required: be=1000, `bus_addr_o`=0x100, `load_data_o`=0xFFFF_FF80, `load_valid_o` pulse in cycle 2, `stall_o` high in cycles 0–1.
- LHU 1101, addr 0x202, rdata 0x9ABC_1234.
  - Required: be=1100, `load_data_o`=0x0000_9ABC. The same access as LH gives 0xFFFF_9ABC.
- SH 1110, addr 0x006, data 0x1234_BEEF, ack after 3 wait cycles.
  - Required: `bus_we_o`=1, be=1100, `bus_wdata_o`=0xBEEF_BEEF held stable until ack, no `load_valid_o`.
- LW with ack never returned, TIMEOUT=64.
  - Required: `bus_req_o` high exactly 64 cycles, then `err_o` and `load_valid_o` pulse with data 0, then stall released.
- LW at addr 0x102.
  - With macro: no `bus_req_o`, `err_o` pulse in cycle 1.
  - Without macro: `bus_addr_o`=0x100, be=1111, no error.
- `rst_ni` low during BUS of an SW.
  - Required: `bus_req_o` and `stall_o` drop to 0 in the same cycle. An ack arriving after reset release causes no pulse, and the next access behaves normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory responder for the RV32IM pipeline.
// Turns a 4-bit read_write access code into one single-outstanding
// request/acknowledge bus transaction. It generates byte enables and
// lane-replicated store data, extracts and extends load data, and stalls the
// pipeline until the access completes.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the bus and finish with err_o.
//   undefined : misaligned low address bits are masked and the access proceeds.
//
// Ports:
//   clk_i, rst_ni       clock (rising edge), async active-low reset
//   req_valid_i         MEM stage holds a valid instruction
//   read_write_i[3:0]   access code; bit3=0 means no access
//   addr_i, store_data_i  byte address and rs2 value
//   stall_o             freeze IF..MEM (combinational)
//   load_data_o, load_valid_o  extended load result and its one-cycle pulse
//   err_o               one-cycle pulse on misalignment trap or timeout
//   bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o  bus request side
//   bus_ack_i, bus_rdata_i  bus completion and read data
//   state_o             current FSM state (0 IDLE, 1 BUS, 2 DONE) for observation
//
// Bus handshake: bus_req_o rises the cycle after an accept and stays high,
// with address/we/be/wdata stable, until the first cycle in which bus_ack_i
// is sampled high (or the timeout fires). bus_ack_i is a single-cycle
// completion, and bus_rdata_i is only sampled in that cycle; ack outside BUS
// is ignored.
module mem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic [3:0]  read_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [1:0]  state_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic [1:0] size_of(input logic [3:0] c);
    case (c)
      4'b1000, 4'b1100, 4'b1011: size_of = SZ_BYTE;
      4'b1001, 4'b1101, 4'b1110: size_of = SZ_HALF;
      default:                   size_of = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] c);
    is_store = (c == 4'b1011) || (c == 4'b1110) || (c == 4'b1111);
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    code_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          accept, misalign;

  assign accept = req_valid_i & read_write_i[3];

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (size_of(read_write_i))
      SZ_HALF: misalign = addr_i[0];
      SZ_WORD: misalign = |addr_i[1:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = misalign ? DONE : BUS;
      BUS:     if (bus_ack_i || (cnt_q == CNT_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched access, captured read data, timeout counter, error flag.
  // An ack on the final count wins over the timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      code_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          code_q  <= read_write_i;
          addr_q  <= addr_i;
          wdata_q <= store_data_i;
          rdata_q <= '0;
          cnt_q   <= '0;
          err_q   <= misalign;
        end
        BUS: begin
          if (bus_ack_i)               rdata_q <= bus_rdata_i;
          else if (cnt_q == CNT_LAST)  err_q   <= 1'b1;
          else                         cnt_q   <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Lane logic on the latched access. Half uses lane addr[1], which also
  // masks addr[0] when misaligned accesses are allowed through.
  logic [3:0]  be;
  logic [31:0] wdata_rep, ext_data;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        sgn;

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_q;
    case (size_of(code_q))
      SZ_BYTE: begin
        be        = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lb = 8'h00;
    case (addr_q[1:0])
      2'd0: lb = rdata_q[7:0];
      2'd1: lb = rdata_q[15:8];
      2'd2: lb = rdata_q[23:16];
      2'd3: lb = rdata_q[31:24];
      default: lb = 8'h00;
    endcase
    lh  = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    // LBU/LHU have bit2 set; LB/LH do not.
    sgn = ~code_q[2];
    case (size_of(code_q))
      SZ_BYTE: ext_data = {{24{sgn & lb[7]}}, lb};
      SZ_HALF: ext_data = {{16{sgn & lh[15]}}, lh};
      default: ext_data = rdata_q;
    endcase
  end

  // Outputs
  always_comb begin
    stall_o      = ((state_q == IDLE) && accept) || (state_q == BUS);
    bus_req_o    = (state_q == BUS);
    bus_we_o     = (state_q == BUS) && is_store(code_q);
    bus_addr_o   = (state_q == BUS) ? {addr_q[31:2], 2'b00} : 32'h0;
    bus_be_o     = (state_q == BUS) ? be : 4'b0000;
    bus_wdata_o  = (state_q == BUS) ? wdata_rep : 32'h0;
    load_valid_o = (state_q == DONE) && !is_store(code_q);
    err_o        = (state_q == DONE) && err_q;
    load_data_o  = (load_valid_o && !err_q) ? ext_data : 32'h0;
    state_o      = state_q;
  end

endmodule
